// File: rtl/filtro_pkg.sv
// rtl/filtro_pkg.sv - shared constants for the IIR filter and band sequencer
//   COEF_W/COEF_FRAC : Q8.14 coefficient format used by the coefficient muxes
//   BAND_*           : 2-bit band codes carried on the shared coefficient select
//   seq_state_e      : state encoding of the band-change sequencer
package filtro_pkg;

    localparam int COEF_W    = 22;
    localparam int COEF_FRAC = 14;

    localparam logic [1:0] BAND_OFF  = 2'b00;
    localparam logic [1:0] BAND_LOW  = 2'b01;
    localparam logic [1:0] BAND_MID  = 2'b10;
    localparam logic [1:0] BAND_HIGH = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_CLEAR     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_e;

endpackage

// File: rtl/coef_band_sequencer.sv
// rtl/coef_band_sequencer.sv - sample-aligned band change sequencer for the IIR filter
//   clk, reset        : single clock, synchronous active-high reset
//   band_req/req_valid: band request strobe from the switch/UI logic
//   sample_tick       : 1-clk strobe at the sample rate
//   sel               : registered coefficient select fanned out to every coefficient mux
//   clear_state       : clears the filter delay registers while the new select takes effect
//   mute              : forces the DAC-side output to 0 while a change is in flight
//   busy              : high whenever the sequencer is not idle
//   ack               : 1-clk pulse once the requested band is fully in effect
module coef_band_sequencer
    import filtro_pkg::*;
#(
    parameter int CLEAR_CYCLES   = 2,
    parameter int SETTLE_SAMPLES = 4,
    parameter int CNT_W          = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] band_req,
    input  logic       req_valid,
    input  logic       sample_tick,
    output logic [1:0] sel,
    output logic       clear_state,
    output logic       mute,
    output logic       busy,
    output logic       ack
);

    // Terminal values for the shared counter, which counts up from zero in both phases.
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       target_q, target_d;
    logic [1:0]       pend_band_q, pend_band_d;
    logic             pend_valid_q, pend_valid_d;
    logic [1:0]       sel_q, sel_d;
    logic             clear_q, clear_d;
    logic             mute_q, mute_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             done_has_req;
    logic [1:0]       done_band;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            target_q     <= BAND_OFF;
            pend_band_q  <= BAND_OFF;
            pend_valid_q <= 1'b0;
            sel_q        <= BAND_OFF;
            clear_q      <= 1'b0;
            mute_q       <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            target_q     <= target_d;
            pend_band_q  <= pend_band_d;
            pend_valid_q <= pend_valid_d;
            sel_q        <= sel_d;
            clear_q      <= clear_d;
            mute_q       <= mute_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        target_d     = target_q;
        pend_band_d  = pend_band_q;
        pend_valid_d = pend_valid_q;
        sel_d        = sel_q;
        clear_d      = 1'b0;
        mute_d       = mute_q;
        ack_d        = 1'b0;

        // In DONE, a request arriving in the same clock supersedes whatever was pending.
        done_has_req = req_valid | pend_valid_q;
        done_band    = req_valid ? band_req : pend_band_q;

        // Any request while busy lands in the 1-deep pending slot; the newest one wins.
        if (state_q != ST_IDLE && req_valid) begin
            pend_valid_d = 1'b1;
            pend_band_d  = band_req;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (band_req == sel_q) begin
                        ack_d = 1'b1;
                    end else begin
                        target_d = band_req;
                        state_d  = ST_WAIT_TICK;
                        mute_d   = 1'b1;
                    end
                end
            end
            ST_WAIT_TICK: begin
                if (sample_tick) begin
                    state_d = ST_CLEAR;
                    sel_d   = target_q;
                    clear_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    cnt_d = '0;
                    if (SETTLE_SAMPLES == 0) begin
                        state_d = ST_DONE;
                        ack_d   = 1'b1;
                        mute_d  = 1'b0;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    clear_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (sample_tick) begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        ack_d   = 1'b1;
                        mute_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // A pending band equal to the one just applied is dropped without a second ack.
                pend_valid_d = 1'b0;
                if (done_has_req && done_band != sel_q) begin
                    target_d = done_band;
                    state_d  = ST_WAIT_TICK;
                    mute_d   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mute_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign sel         = sel_q;
    assign clear_state = clear_q;
    assign mute        = mute_q;
    assign busy        = busy_q;
    assign ack         = ack_q;

endmodule

// File: tb/tb_coef_band_sequencer.sv
// tb/tb_coef_band_sequencer.sv - self-checking bench for coef_band_sequencer
module tb_coef_band_sequencer;
    import filtro_pkg::*;

    localparam int CLEAR_CYCLES   = 2;
    localparam int SETTLE_SAMPLES = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] band_req = 2'b00;
    logic       req_valid = 1'b0;
    logic       sample_tick = 1'b0;
    logic [1:0] sel;
    logic       clear_state, mute, busy, ack;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    coef_band_sequencer #(
        .CLEAR_CYCLES  (CLEAR_CYCLES),
        .SETTLE_SAMPLES(SETTLE_SAMPLES),
        .CNT_W         (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .band_req   (band_req),
        .req_valid  (req_valid),
        .sample_tick(sample_tick),
        .sel        (sel),
        .clear_state(clear_state),
        .mute       (mute),
        .busy       (busy),
        .ack        (ack)
    );

    // Reference model: remaining-work counters per phase of a band change.
    int m_sel, m_tgt, m_pend, m_clr_left, m_set_left;
    bit m_busy, m_need_tick, m_ack_phase, m_echo;

    task automatic model_reset();
        m_sel = 0; m_tgt = 0; m_pend = -1; m_clr_left = 0; m_set_left = 0;
        m_busy = 0; m_need_tick = 0; m_ack_phase = 0; m_echo = 0;
    endtask

    task automatic model_step(input bit rv, input int rb, input bit tk);
        m_echo = 0;
        if (!m_busy) begin
            if (rv) begin
                if (rb == m_sel) m_echo = 1;
                else begin m_tgt = rb; m_busy = 1; m_need_tick = 1; end
            end
        end else begin
            if (rv) m_pend = rb;
            if (m_ack_phase) begin
                m_ack_phase = 0;
                if (m_pend >= 0 && m_pend != m_sel) begin
                    m_tgt = m_pend; m_need_tick = 1;
                end else begin
                    m_busy = 0;
                end
                m_pend = -1;
            end else if (m_need_tick) begin
                if (tk) begin m_need_tick = 0; m_sel = m_tgt; m_clr_left = CLEAR_CYCLES; end
            end else if (m_clr_left > 0) begin
                m_clr_left--;
                if (m_clr_left == 0) begin
                    if (SETTLE_SAMPLES == 0) m_ack_phase = 1;
                    else m_set_left = SETTLE_SAMPLES;
                end
            end else if (m_set_left > 0 && tk) begin
                m_set_left--;
                if (m_set_left == 0) m_ack_phase = 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic step(input bit rst, input bit rv, input logic [1:0] rb, input bit tk);
        reset = rst; req_valid = rv; band_req = rb; sample_tick = tk;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(rv, int'(rb), tk);
        #1;
        reset = 1'b0; req_valid = 1'b0; sample_tick = 1'b0;
        check("sel",   int'(sel),         m_sel);
        check("mute",  int'(mute),        int'(m_busy && !m_ack_phase));
        check("busy",  int'(busy),        int'(m_busy));
        check("ack",   int'(ack),         int'(m_ack_phase || m_echo));
        check("clear", int'(clear_state), int'(m_clr_left > 0));
    endtask

    typedef struct {
        bit         rv;
        logic [1:0] rb;
        bit         tk;
        logic [1:0] e_sel;
        bit         e_mute, e_busy, e_ack, e_clr;
    } vec_t;

    vec_t vecs[15];

    // Concurrent properties over the whole run.
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= reset;

    a_sel_stable: assert property (@(posedge clk) disable iff (reset || rst_q)
        (sel != $past(sel)) |-> (mute && $past(mute)))
        else begin n_checks++; n_fail++; $display("FAIL sva_sel_stable: sel changed while unmuted at %0t", $time); end
    a_ack_done: assert property (@(posedge clk) disable iff (reset || rst_q)
        (ack && busy) |-> (dut.state_q == ST_DONE))
        else begin n_checks++; n_fail++; $display("FAIL sva_ack_done: busy ack outside DONE at %0t", $time); end
    a_clear_mute: assert property (@(posedge clk) disable iff (reset || rst_q)
        clear_state |-> mute)
        else begin n_checks++; n_fail++; $display("FAIL sva_clear_mute: clear without mute at %0t", $time); end

    int acks, first_sel, first_ack;
    bit saw_high;

    initial begin
        model_reset();
        vecs[0]  = '{1, 2'd0, 0, 2'd0, 0, 0, 1, 0};
        vecs[1]  = '{0, 2'd0, 0, 2'd0, 0, 0, 0, 0};
        vecs[2]  = '{1, 2'd3, 1, 2'd0, 1, 1, 0, 0};
        vecs[3]  = '{0, 2'd0, 0, 2'd0, 1, 1, 0, 0};
        vecs[4]  = '{0, 2'd0, 1, 2'd3, 1, 1, 0, 1};
        vecs[5]  = '{0, 2'd0, 0, 2'd3, 1, 1, 0, 1};
        vecs[6]  = '{0, 2'd0, 0, 2'd3, 1, 1, 0, 0};
        vecs[7]  = '{0, 2'd0, 1, 2'd3, 1, 1, 0, 0};
        vecs[8]  = '{0, 2'd0, 0, 2'd3, 1, 1, 0, 0};
        vecs[9]  = '{0, 2'd0, 1, 2'd3, 1, 1, 0, 0};
        vecs[10] = '{0, 2'd0, 1, 2'd3, 1, 1, 0, 0};
        vecs[11] = '{0, 2'd0, 1, 2'd3, 0, 1, 1, 0};
        vecs[12] = '{0, 2'd0, 0, 2'd3, 0, 0, 0, 0};
        vecs[13] = '{1, 2'd3, 0, 2'd3, 0, 0, 1, 0};
        vecs[14] = '{0, 2'd0, 0, 2'd3, 0, 0, 0, 0};

        // Reset, then idle: outputs stay at their reset values.
        step(1, 0, 2'd0, 0);
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 2'd0, (i % 3) == 0);
            acks += int'(ack);
        end
        check("idle_acks", acks, 0);

        // Table: echo ack, request on a tick, full change to 11, echo of 11.
        for (int i = 0; i < 15; i++) begin
            step(0, vecs[i].rv, vecs[i].rb, vecs[i].tk);
            check($sformatf("vec%0d_sel", i),   int'(sel),         int'(vecs[i].e_sel));
            check($sformatf("vec%0d_mute", i),  int'(mute),        int'(vecs[i].e_mute));
            check($sformatf("vec%0d_busy", i),  int'(busy),        int'(vecs[i].e_busy));
            check($sformatf("vec%0d_ack", i),   int'(ack),         int'(vecs[i].e_ack));
            check($sformatf("vec%0d_clear", i), int'(clear_state), int'(vecs[i].e_clr));
        end

        // Request 10, then 11 and 01 during SETTLE; ticks every 8 clocks.
        step(1, 0, 2'd0, 0);
        acks = 0; first_sel = -1; first_ack = -1; saw_high = 0;
        for (int i = 0; i < 120; i++) begin
            if (i == 0)       step(0, 1, 2'd2, 0);
            else if (i == 22) step(0, 1, 2'd3, (i % 8) == 7);
            else if (i == 26) step(0, 1, 2'd1, (i % 8) == 7);
            else              step(0, 0, 2'd0, (i % 8) == 7);
            if (sel == 2'd2 && first_sel < 0) first_sel = i;
            if (ack && first_ack < 0) first_ack = i;
            if (sel == 2'd3) saw_high = 1;
            acks += int'(ack);
        end
        check("lastwins_first_sel_clk", first_sel, 7);
        check("lastwins_first_ack_clk", first_ack, 39);
        check("lastwins_acks", acks, 2);
        check("lastwins_no_11", int'(saw_high), 0);
        check("lastwins_final_sel", int'(sel), 1);

        // Reset during SETTLE with a pending request: everything returns to reset.
        step(1, 0, 2'd0, 0);
        for (int i = 0; i < 21; i++) begin
            if (i == 0)       step(0, 1, 2'd1, 0);
            else if (i == 18) step(0, 1, 2'd2, 0);
            else if (i == 20) step(1, 0, 2'd0, 0);
            else              step(0, 0, 2'd0, (i % 8) == 7);
        end
        check("rst_sel", int'(sel), 0);
        check("rst_mute", int'(mute), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ack", int'(ack), 0);
        acks = 0;
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 2'd0, (i % 8) == 7);
            acks += int'(ack);
        end
        check("rst_pending_lost_acks", acks, 0);
        check("rst_pending_lost_sel", int'(sel), 0);

        // Randomized traffic against the model.
        step(1, 0, 2'd0, 0);
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 11) == 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
